// File: rtl/instruction_fetch.sv
// Instruction fetch stage: walks fetch_pc through a combinational instruction
// memory and buffers {pc, instr} pairs in a small FIFO for the decoder.
module instruction_fetch #(
    parameter int SIZE   = 64,
    parameter int ADDR_W = $clog2(SIZE),
    parameter int DEPTH  = 2
) (
    input  logic              clk,
    input  logic              rst,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [31:0]       imem_data,
    input  logic              redirect_valid,
    input  logic [31:0]       redirect_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_instr,
    output logic [31:0]       out_pc
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [31:0]      fetch_pc;
    logic [31:0]      pc_q    [DEPTH];
    logic [31:0]      instr_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;
    logic             full;
    logic             push;
    logic             pop;
    logic             unused_redirect_lsbs;

    // Handshake: the head transfers on a rising edge where out_valid and
    // out_ready are both high; a redirect in that cycle flushes the head
    // instead, so nothing is consumed.
    assign out_valid = (count != '0);
    assign full      = (count == CNT_W'(DEPTH));
    assign pop       = out_valid && out_ready && !redirect_valid;
    assign push      = !redirect_valid && (!full || pop);

    assign imem_addr = fetch_pc[ADDR_W+1:2];
    assign out_pc    = pc_q[rd_ptr];
    assign out_instr = instr_q[rd_ptr];

    // Targets are word aligned; the low two bits are dropped on purpose.
    assign unused_redirect_lsbs = ^redirect_pc[1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                pc_q[i]    <= '0;
                instr_q[i] <= '0;
            end
        end else if (redirect_valid) begin
            fetch_pc <= {redirect_pc[31:2], 2'b00};
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
        end else begin
            if (push) begin
                pc_q[wr_ptr]    <= fetch_pc;
                instr_q[wr_ptr] <= imem_data;
                wr_ptr          <= wr_ptr + PTR_W'(1);
                fetch_pc        <= fetch_pc + 32'd4;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            // Push together with pop leaves the occupancy unchanged, even when full.
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: vector table for the streaming,
// redirect and wrap cases, plus hand sequences for stall and async reset.
module tb_instruction_fetch;

    localparam int SIZE   = 64;
    localparam int ADDR_W = 6;
    localparam int DEPTH  = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_data;
    logic              redirect_valid = 1'b0;
    logic [31:0]       redirect_pc = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [31:0]       out_instr;
    logic [31:0]       out_pc;

    int n_checks = 0;
    int n_fail   = 0;

    instruction_fetch #(.SIZE(SIZE), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_addr      (imem_addr),
        .imem_data      (imem_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc)
    );

    always #5 clk = ~clk;

    // Memory model: word i holds 0x1000_0000 + i.
    assign imem_data = 32'h1000_0000 + 32'(imem_addr);

    typedef struct {
        string       name;
        logic        redir;
        logic [31:0] rpc;
        logic        ready;
        logic        exp_valid;
        logic [31:0] exp_addr;
        logic [31:0] exp_pc;
        logic [31:0] exp_instr;
    } vec_t;

    vec_t vecs[16];

    function automatic vec_t mk(string name, logic redir, logic [31:0] rpc, logic ready,
                                logic ev, logic [31:0] ea, logic [31:0] ep, logic [31:0] ei);
        vec_t v;
        v.name = name; v.redir = redir; v.rpc = rpc; v.ready = ready;
        v.exp_valid = ev; v.exp_addr = ea; v.exp_pc = ep; v.exp_instr = ei;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_head(input string name, input logic ev, input logic [31:0] ea,
                              input logic [31:0] ep, input logic [31:0] ei);
        check({name, ".valid"}, 32'(out_valid), 32'(ev));
        check({name, ".addr"}, 32'(imem_addr), ea);
        if (ev) begin
            check({name, ".pc"}, out_pc, ep);
            check({name, ".instr"}, out_instr, ei);
        end
    endtask

    initial begin
        vecs[0]  = mk("stream0",   0, 32'h0,        1, 1, 1,  32'h0,        32'h1000_0000);
        vecs[1]  = mk("stream1",   0, 32'h0,        1, 1, 2,  32'h4,        32'h1000_0001);
        vecs[2]  = mk("stream2",   0, 32'h0,        1, 1, 3,  32'h8,        32'h1000_0002);
        vecs[3]  = mk("redir43",   1, 32'h43,       1, 0, 16, 32'h0,        32'h0);
        vecs[4]  = mk("tgt40",     0, 32'h0,        0, 1, 17, 32'h40,       32'h1000_0010);
        vecs[5]  = mk("fill",      0, 32'h0,        0, 1, 18, 32'h40,       32'h1000_0010);
        vecs[6]  = mk("full_hold", 0, 32'h0,        0, 1, 18, 32'h40,       32'h1000_0010);
        vecs[7]  = mk("redir_fc",  1, 32'hFC,       1, 0, 63, 32'h0,        32'h0);
        vecs[8]  = mk("tgt_fc",    0, 32'h0,        1, 1, 0,  32'hFC,       32'h1000_003F);
        vecs[9]  = mk("pc100",     0, 32'h0,        1, 1, 1,  32'h100,      32'h1000_0000);
        vecs[10] = mk("b2b_a",     1, 32'h208,      1, 0, 2,  32'h0,        32'h0);
        vecs[11] = mk("b2b_b",     1, 32'h30,       1, 0, 12, 32'h0,        32'h0);
        vecs[12] = mk("tgt30",     0, 32'h0,        1, 1, 13, 32'h30,       32'h1000_000C);
        vecs[13] = mk("redir_top", 1, 32'hFFFF_FFFC, 0, 0, 63, 32'h0,       32'h0);
        vecs[14] = mk("tgt_top",   0, 32'h0,        0, 1, 0,  32'hFFFF_FFFC, 32'h1000_003F);
        vecs[15] = mk("wrap0",     0, 32'h0,        1, 1, 1,  32'h0,        32'h1000_0000);

        // Reset state while rst is high.
        #12;
        check_head("reset", 0, 0, 32'h0, 32'h0);
        check("reset.pc", out_pc, 32'h0);
        check("reset.instr", out_instr, 32'h0);

        @(posedge clk); #1 rst = 1'b0;
        foreach (vecs[i]) begin
            @(negedge clk);
            redirect_valid = vecs[i].redir;
            redirect_pc    = vecs[i].rpc;
            out_ready      = vecs[i].ready;
            @(posedge clk); #1;
            check_head(vecs[i].name, vecs[i].exp_valid, vecs[i].exp_addr,
                       vecs[i].exp_pc, vecs[i].exp_instr);
        end

        // Stall from reset release: queue fills to DEPTH and fetch holds.
        @(negedge clk);
        redirect_valid = 1'b0;
        out_ready = 1'b0;
        rst = 1'b1;
        #1 check_head("stall_rst", 0, 0, 32'h0, 32'h0);
        @(posedge clk); #1 rst = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            @(posedge clk); #1;
            check_head($sformatf("stall%0d", k), 1, (k < 2) ? k : 2, 32'h0, 32'h1000_0000);
        end
        @(negedge clk);
        out_ready = 1'b1;
        #1 check_head("drain0", 1, 2, 32'h0, 32'h1000_0000);
        for (int k = 1; k <= 3; k++) begin
            @(posedge clk); #1;
            check_head($sformatf("drain%0d", k), 1, 2 + k, 32'(4 * k), 32'h1000_0000 + 32'(k));
        end

        // Asynchronous reset between edges while streaming.
        @(negedge clk); #1 rst = 1'b1;
        #1;
        check_head("async_rst", 0, 0, 32'h0, 32'h0);
        check("async_rst.pc", out_pc, 32'h0);
        check("async_rst.instr", out_instr, 32'h0);
        @(posedge clk); #1 rst = 1'b0;
        @(posedge clk); #1;
        check_head("restart0", 1, 1, 32'h0, 32'h1000_0000);
        @(posedge clk); #1;
        check_head("restart1", 1, 2, 32'h4, 32'h1000_0001);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
